dmem_access_ctrl: RTL

- Multi-cycle controller that sequences all data-memory traffic onto a single-port, synchronous-read, word-wide data memory.
- Performs byte-lane extraction, sign/zero extension and read-modify-write merging for sub-word stores.
- Shares the memory between the CPU MEM stage (priority) and the debug/PDU port.
- Sits between the MEM stage, the debug unit and the data-memory IP.

---
 rtl/dmem_access_ctrl_pkg.sv | 25 ++
 rtl/dmem_access_ctrl_if.sv | 44 ++++
 rtl/dmem_access_ctrl_lane_align.sv | 53 +++++
 rtl/dmem_access_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access types,
// FSM states and port-ownership constants.
package dmem_pkg;

  localparam logic [3:0] ACC_LW  = 4'b0001;
  localparam logic [3:0] ACC_LH  = 4'b0010;
  localparam logic [3:0] ACC_LB  = 4'b0011;
  localparam logic [3:0] ACC_LHU = 4'b0100;
  localparam logic [3:0] ACC_LBU = 4'b0101;
  localparam logic [3:0] ACC_SW  = 4'b1001;
  localparam logic [3:0] ACC_SH  = 4'b1010;
  localparam logic [3:0] ACC_SB  = 4'b1011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the CPU request port, debug port and data-memory port.
// Handshake: a requester holds req and its fields stable until it sees a
// one-cycle done pulse; rdata/err are meaningful only while done is high.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic [3:0]        cpu_access;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_done;
  logic              cpu_err;
  logic [31:0]       cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_done;
  logic [31:0]       dbg_rdata;

  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic              mem_we;
  logic [31:0]       mem_q;

  modport slave (
    input  cpu_req, cpu_access, cpu_addr, cpu_wdata,
    output cpu_done, cpu_err, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_done, dbg_rdata,
    output mem_a, mem_d, mem_we,
    input  mem_q
  );

  modport master (
    output cpu_req, cpu_access, cpu_addr, cpu_wdata,
    input  cpu_done, cpu_err, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_done, dbg_rdata,
    input  mem_a, mem_d, mem_we,
    output mem_q
  );
endinterface

// File: rtl/dmem_access_ctrl_lane_align.sv
// Byte-lane logic: load extract/extend, sub-word store merge, and the
// alignment/encoding legality check for an incoming CPU request.
module lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] mem_q_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [3:0]  acc_i,
  input  logic [3:0]  chk_acc_i,
  input  logic [1:0]  chk_addr_lo_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o,
  output logic        legal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_q_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = mem_q_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (acc_i)
      ACC_LW:  load_o = mem_q_i;
      ACC_LH:  load_o = {{16{half_sel[15]}}, half_sel};
      ACC_LB:  load_o = {{24{byte_sel[7]}}, byte_sel};
      ACC_LHU: load_o = {16'h0000, half_sel};
      ACC_LBU: load_o = {24'h000000, byte_sel};
      default: load_o = 32'h0;
    endcase
  end

  // Lanes not covered by the store keep the value just read from memory.
  always_comb begin
    merge_o = mem_q_i;
    case (acc_i)
      ACC_SW:  merge_o = wdata_i;
      ACC_SH:  merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      ACC_SB:  merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      default: ;
    endcase
  end

  always_comb begin
    case (chk_acc_i)
      ACC_LW, ACC_SW:          legal_o = (chk_addr_lo_i == 2'b00);
      ACC_LH, ACC_LHU, ACC_SH: legal_o = ~chk_addr_lo_i[0];
      ACC_LB, ACC_LBU, ACC_SB: legal_o = 1'b1;
      default:                 legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences CPU (priority) and debug traffic onto a single-port,
// synchronous-read data memory, including read-modify-write sub-word stores.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  dmem_access_ctrl_if.slave   bus,
  output state_t              state_o
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        acc_q, acc_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       mem_d_q, mem_d_d;

  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        cpu_legal;
  logic        is_load_ret;
  logic        unused_addr_bits;

  lane_align u_lane_align (
    .mem_q_i       (bus.mem_q),
    .wdata_i       (wdata_q),
    .addr_lo_i     (addr_lo_q),
    .acc_i         (acc_q),
    .chk_acc_i     (bus.cpu_access),
    .chk_addr_lo_i (bus.cpu_addr[1:0]),
    .load_o        (load_data),
    .merge_o       (merge_data),
    .legal_o       (cpu_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_CPU;
      acc_q     <= 4'h0;
      addr_lo_q <= 2'b00;
      wdata_q   <= 32'h0;
      mem_a_q   <= '0;
      mem_d_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      acc_q     <= acc_d;
      addr_lo_q <= addr_lo_d;
      wdata_q   <= wdata_d;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
    end
  end

  // Debug accesses are latched as word load/store so MRG/WR decode is shared.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    acc_d     = acc_q;
    addr_lo_d = addr_lo_q;
    wdata_d   = wdata_q;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          owner_d   = OWN_CPU;
          acc_d     = bus.cpu_access;
          addr_lo_d = bus.cpu_addr[1:0];
          wdata_d   = bus.cpu_wdata;
          mem_a_d   = bus.cpu_addr[ADDR_W+1:2];
          mem_d_d   = bus.cpu_wdata;
          if (!cpu_legal)                     state_d = ERR;
          else if (bus.cpu_access == ACC_SW)  state_d = WR;
          else                                state_d = RD;
        end else if (bus.dbg_req) begin
          owner_d   = OWN_DBG;
          acc_d     = bus.dbg_we ? ACC_SW : ACC_LW;
          addr_lo_d = 2'b00;
          wdata_d   = bus.dbg_wdata;
          mem_a_d   = bus.dbg_addr[ADDR_W+1:2];
          mem_d_d   = bus.dbg_wdata;
          state_d   = bus.dbg_we ? WR : RD;
        end
      end
      RD:  state_d = MRG;
      MRG: begin
        if (acc_q[3]) begin
          mem_d_d = merge_data;
          state_d = WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign is_load_ret   = (state_q == MRG) && !acc_q[3];

  assign bus.cpu_done  = (owner_q == OWN_CPU) &&
                         ((state_q == WR) || (state_q == ERR) || is_load_ret);
  assign bus.cpu_err   = (owner_q == OWN_CPU) && (state_q == ERR);
  assign bus.cpu_rdata = ((owner_q == OWN_CPU) && is_load_ret) ? load_data : 32'h0;
  assign bus.dbg_done  = (owner_q == OWN_DBG) && ((state_q == WR) || is_load_ret);
  assign bus.dbg_rdata = ((owner_q == OWN_DBG) && is_load_ret) ? bus.mem_q : 32'h0;

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_d     = mem_d_q;
  assign bus.mem_we    = (state_q == WR);
  assign state_o       = state_q;

  assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.dbg_addr[31:ADDR_W+2],
                              bus.dbg_addr[1:0]};

endmodule
